// File: rtl/hdmi_period_ctrl.sv
// Purpose : raster timing generator and TMDS period scheduler (blank/control, guard, video).
// Latency : all outputs are registered; outputs in cycle n+1 decode the raster position of cycle n.
// Backpres: none; the raster free-runs while en=1, and en=0 clears it to (0,0) and holds it there.
//
// Ports:
//   clk          pixel clock
//   n_rst        synchronous reset, active HIGH (despite the name); has priority over en
//   en           run enable; low clears the raster and forces outputs to their reset values
//   sel          output mux select: 00 blank/control, 01 guard band, 10 video (11 never driven)
//   ctl          CTL3..CTL0; 0001 during the video preamble, otherwise 0000
//   hsync/vsync  sync outputs, asserted level SYNC_POL
//   de           data enable, high exactly when sel=10
//   pixel_x/y    active pixel coordinates, 0 outside video
//   frame_start  one-cycle pulse when the outputs reflect raster position (0,0)
module hdmi_period_ctrl #(
    parameter int   H_ACTIVE     = 640,
    parameter int   H_FRONT      = 16,
    parameter int   H_SYNC       = 96,
    parameter int   H_BACK       = 48,
    parameter int   V_ACTIVE     = 480,
    parameter int   V_FRONT      = 10,
    parameter int   V_SYNC       = 2,
    parameter int   V_BACK       = 33,
    parameter int   PREAMBLE_LEN = 8,
    parameter int   GUARD_LEN    = 2,
    parameter logic SYNC_POL     = 1'b1
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        en,
    output logic [1:0]  sel,
    output logic [3:0]  ctl,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [11:0] pixel_x,
    output logic [11:0] pixel_y,
    output logic        frame_start
);

    // Derived raster geometry. Blanking comes first on each line / frame,
    // so active video starts at hcnt = H_BLANK and vcnt = V_BLANK.
    localparam logic [11:0] H_BLANK   = 12'(H_FRONT + H_SYNC + H_BACK);
    localparam logic [11:0] H_TOTAL   = 12'(H_FRONT + H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [11:0] V_BLANK   = 12'(V_FRONT + V_SYNC + V_BACK);
    localparam logic [11:0] V_TOTAL   = 12'(V_FRONT + V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [11:0] HS_START  = 12'(H_FRONT);
    localparam logic [11:0] HS_END    = 12'(H_FRONT + H_SYNC);
    localparam logic [11:0] VS_START  = 12'(V_FRONT);
    localparam logic [11:0] VS_END    = 12'(V_FRONT + V_SYNC);
    // Guard band sits immediately before active video, preamble immediately before the guard.
    localparam logic [11:0] GB_START  = 12'(H_FRONT + H_SYNC + H_BACK - GUARD_LEN);
    localparam logic [11:0] PRE_START = 12'(H_FRONT + H_SYNC + H_BACK - GUARD_LEN - PREAMBLE_LEN);

    localparam logic [1:0] SEL_CTRL  = 2'b00;
    localparam logic [1:0] SEL_GUARD = 2'b01;
    localparam logic [1:0] SEL_VIDEO = 2'b10;

    // ST_IDLE: raster parked at (0,0), outputs at reset values.
    // ST_RUN : raster advancing, outputs follow the decode.
    // The extra IDLE->RUN step is what delays the (0,0) outputs by one cycle
    // after the counters start: the first enabled edge only arms the raster.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [11:0] hcnt, hcnt_nxt;
    logic [11:0] vcnt, vcnt_nxt;
    logic        advance;

    // Decoded (pre-register) outputs for the current raster position.
    logic [1:0]  d_sel;
    logic [3:0]  d_ctl;
    logic        d_hsync;
    logic        d_vsync;
    logic        d_de;
    logic [11:0] d_px;
    logic [11:0] d_py;
    logic        d_fs;
    logic        line_active;

    // ------------------------------------------------------------------
    // Run-state FSM and raster counter next-state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        advance   = 1'b0;
        hcnt_nxt  = 12'd0;
        vcnt_nxt  = 12'd0;

        case (state)
            ST_IDLE: begin
                // Counters stay at (0,0) on the arming edge.
                if (en) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (en) begin
                    advance = 1'b1;
                    if (hcnt == H_TOTAL - 12'd1) begin
                        hcnt_nxt = 12'd0;
                        if (vcnt == V_TOTAL - 12'd1) begin
                            vcnt_nxt = 12'd0;
                        end else begin
                            vcnt_nxt = vcnt + 12'd1;
                        end
                    end else begin
                        hcnt_nxt = hcnt + 12'd1;
                        vcnt_nxt = vcnt;
                    end
                end else begin
                    // Mid-frame drop abandons the frame: counters clear, no line completion.
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Position decode
    // ------------------------------------------------------------------
    always_comb begin
        d_sel       = SEL_CTRL;
        d_ctl       = 4'b0000;
        d_de        = 1'b0;
        d_px        = 12'd0;
        d_py        = 12'd0;
        line_active = (vcnt >= V_BLANK);

        // Preamble and guard only lead into active lines; vertical-blank
        // lines stay in plain control period for their whole length.
        if (line_active) begin
            if (hcnt >= H_BLANK) begin
                d_sel = SEL_VIDEO;
                d_de  = 1'b1;
                d_px  = hcnt - H_BLANK;
                d_py  = vcnt - V_BLANK;
            end else if (hcnt >= GB_START) begin
                d_sel = SEL_GUARD;
            end else if (hcnt >= PRE_START) begin
                d_ctl = 4'b0001;
            end
        end

        d_hsync = ((hcnt >= HS_START) && (hcnt < HS_END)) ? SYNC_POL : ~SYNC_POL;
        // vsync depends only on vcnt, which changes on the hcnt wrap, so its
        // edges land on hcnt=0 without extra alignment logic.
        d_vsync = ((vcnt >= VS_START) && (vcnt < VS_END)) ? SYNC_POL : ~SYNC_POL;
        d_fs    = (hcnt == 12'd0) && (vcnt == 12'd0);
    end

    // ------------------------------------------------------------------
    // State, counters and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (n_rst) begin
            state       <= ST_IDLE;
            hcnt        <= 12'd0;
            vcnt        <= 12'd0;
            sel         <= SEL_CTRL;
            ctl         <= 4'b0000;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            de          <= 1'b0;
            pixel_x     <= 12'd0;
            pixel_y     <= 12'd0;
            frame_start <= 1'b0;
        end else begin
            state <= state_nxt;
            hcnt  <= hcnt_nxt;
            vcnt  <= vcnt_nxt;
            if (advance) begin
                sel         <= d_sel;
                ctl         <= d_ctl;
                hsync       <= d_hsync;
                vsync       <= d_vsync;
                de          <= d_de;
                pixel_x     <= d_px;
                pixel_y     <= d_py;
                frame_start <= d_fs;
            end else begin
                sel         <= SEL_CTRL;
                ctl         <= 4'b0000;
                hsync       <= ~SYNC_POL;
                vsync       <= ~SYNC_POL;
                de          <= 1'b0;
                pixel_x     <= 12'd0;
                pixel_y     <= 12'd0;
                frame_start <= 1'b0;
            end
        end
    end

endmodule

// File: doc/hdmi_period_ctrl.md
# hdmi_period_ctrl

Video timing and period scheduler for the HDMI/DVI transmit path. It runs horizontal and vertical raster counters and drives the 2-bit period select of the TMDS output mux: control/blanking, guard band, or video. It also produces the CTL preamble bits, hsync/vsync, data-enable and pixel coordinates for the pixel source. It sits between the pixel source and the per-channel output muxes and encoders.

## Interface
- H_ACTIVE, 640: active pixels per line
- H_FRONT, 16: horizontal front porch, in pixel clocks
- H_SYNC, 96: hsync width, in pixel clocks
- H_BACK, 48: horizontal back porch, in pixel clocks; must be >= PREAMBLE_LEN + GUARD_LEN
- V_ACTIVE, 480: active lines per frame
- V_FRONT, 10: vertical front porch, in lines
- V_SYNC, 2: vsync width, in lines
- V_BACK, 33: vertical back porch, in lines
- PREAMBLE_LEN, 8: video preamble length, in pixel clocks
- GUARD_LEN, 2: video leading guard band length, in pixel clocks
- SYNC_POL, 1: asserted level of hsync/vsync
- clk  in  1  pixel clock
- n_rst  in  1  reset; synchronous, active-high (despite the name)
- en  in  1  run enable
- sel  out  2  mux select: 00 blank/control, 01 guard, 10 video; 11 never driven
- ctl  out  4  CTL3..CTL0 for channels 1/2
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- de  out  1  data enable; high exactly when sel=10
- pixel_x  out  12  active column, 0..H_ACTIVE-1; 0 outside video
- pixel_y  out  12  active row, 0..V_ACTIVE-1; 0 outside video
- frame_start  out  1  one-cycle pulse when the outputs reflect raster position (0,0)

## Operation
- Derived values:
  - H_BLANK = H_FRONT + H_SYNC + H_BACK; H_TOTAL = H_BLANK + H_ACTIVE
  - V_BLANK = V_FRONT + V_SYNC + V_BACK; V_TOTAL = V_BLANK + V_ACTIVE
  - Counters hcnt and vcnt are 12-bit unsigned.
- Line order (hcnt): front porch, then sync, then back porch, then active at hcnt >= H_BLANK.
- Frame order (vcnt): the same ordering applies vertically; lines with vcnt >= V_BLANK are active lines.
- Counter advance, when en=1:
  - hcnt increments every cycle and wraps H_TOTAL-1 -> 0.
  - On that wrap, vcnt increments and wraps V_TOTAL-1 -> 0.
- Decode of position (hcnt, vcnt):
  - video when vcnt >= V_BLANK and hcnt >= H_BLANK. Gives sel=10, de=1, pixel_x=hcnt-H_BLANK, pixel_y=vcnt-V_BLANK.
  - guard when vcnt >= V_BLANK and H_BLANK-GUARD_LEN <= hcnt < H_BLANK. Gives sel=01.
  - preamble when vcnt >= V_BLANK and H_BLANK-GUARD_LEN-PREAMBLE_LEN <= hcnt < H_BLANK-GUARD_LEN. Gives sel=00, ctl=0001.
  - every other position gives sel=00, ctl=0000.
  - Lines in vertical blank never produce preamble or guard.
- hsync = SYNC_POL when H_FRONT <= hcnt < H_FRONT+H_SYNC; otherwise ~SYNC_POL. Applies on every line.
- vsync = SYNC_POL when V_FRONT <= vcnt < V_FRONT+V_SYNC; otherwise ~SYNC_POL. Transitions are aligned to hcnt=0.
- frame_start = 1 for position (0,0) only.
- en=0:
  - Counters are cleared to (0,0) and held.
  - Outputs go to reset values the next cycle.
  - A mid-line en drop abandons the frame; there is no completion of the current line.

## Timing
- All outputs are registered. Outputs in cycle n+1 are the decode of the counters in cycle n.
- Reset values (n_rst=1 sampled at an edge): counters 0, sel=00, ctl=0000, hsync=vsync=~SYNC_POL, de=0, pixel_x=pixel_y=0, frame_start=0.
- Start-up:
  - On the first edge with n_rst=0 and en=1, the counters hold (0,0) and begin advancing.
  - Outputs for (0,0), including the frame_start pulse, appear on the following edge.
  - Startup latency is therefore 1 cycle after counter start.
- Reset mid-frame takes effect at the next edge and has the same result as from power-up. Reset has priority over en.
- Sequence into an active line: PREAMBLE_LEN cycles of ctl=0001, then exactly GUARD_LEN cycles of sel=01, then H_ACTIVE cycles of sel=10.
- sel returns to 00 and ctl to 0000 in the cycle after the last active pixel. This is the hcnt wrap into the next front porch.
- Frame period: H_TOTAL*V_TOTAL cycles between frame_start pulses.

## Test plan
Small parameter set: H_ACTIVE=8, H_FRONT=2, H_SYNC=3, H_BACK=12, V_ACTIVE=4, V_FRONT=1, V_SYNC=2, V_BACK=1, defaults otherwise. This gives H_TOTAL=25, V_TOTAL=8. F is the frame_start cycle.
- Reset: hold n_rst=1 for 3 cycles with en=1 -> all outputs at reset values. Release n_rst -> frame_start at the 2nd edge after release.
- Blank lines (lines 0-3): hsync=1 at F+2..F+4, F+27..F+29, and so on; vsync=1 for F+25..F+74. sel=00 and ctl=0000 throughout F..F+99.
- First active line: ctl=0001 at F+107..F+114; sel=01 at F+115..F+116; sel=10 with de=1 and pixel_x 0..7, pixel_y=0 at F+117..F+124; sel=00 at F+125.
- Last active line: pixel_y=3 at F+192..F+199. Next frame_start at F+200, with no guard or preamble on line 0.
- Disable mid-video: drop en at F+120 -> next cycle sel=00, de=0, pixel_x=0. Re-raise en -> frame_start 2 edges later, with a full frame sequence.
- Reset mid-guard: assert n_rst at F+115 -> sel=00 at F+116, not 01. Hold both en=0 and n_rst=1 -> outputs stay at reset values indefinitely.
